// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled 8N1 UART receiver feeding a valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors on parity_err.
module uart_rx_core #(
  parameter int unsigned clk_freq = 32000000,
  parameter int unsigned baudrate = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned   DIV       = clk_freq / (baudrate * 16);
  localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]    sync_live_q;
  logic          fall_edge;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sub_q, sub_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          tick, mid_bit, byte_ok;
`ifdef UART_RX_PARITY_EN
  logic          par_bit_q, par_bit_d;
  logic          perr_q, perr_d;
  logic          parity_bad;

  assign parity_bad = par_bit_q ^ (^shift_q);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b0;
      sync_live_q <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments make each flop take its pre-edge input, so the chain advances one stage per clock.
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q & sync_live_q[1];
      sync_live_q <= {sync_live_q[0], 1'b1};
    end
  end

  // rx_prev_q only tracks real line samples, so a line held low through reset never looks like a start edge.
  assign fall_edge = rx_prev_q & ~rx_s_q;
  assign tick      = (presc_q == PRESC_MAX);
  assign mid_bit   = tick && (sub_q == 4'd15);

  always_comb begin
    // NOTE: every _d starts from a hold/default value; a path that skipped one would infer a latch.
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    sub_d     = tick ? sub_q + 4'd1 : sub_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    byte_ok   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall_edge) begin
          state_d = ST_START;
          presc_d = '0;
          sub_d   = '0;
        end
      end
      ST_START: begin
        if (tick && (sub_q == 4'd7)) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            sub_d     = '0;
            bit_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (mid_bit) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (mid_bit) begin
          par_bit_d = rx_s_q;
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (mid_bit) begin
`ifdef UART_RX_PARITY_EN
          perr_d  = parity_bad;
          byte_ok = rx_s_q & ~parity_bad;
`else
          byte_ok = rx_s_q;
`endif
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A completion in the same cycle as an acceptance refills the register instead of overrunning.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready;
    ovr_d   = 1'b0;
    if (byte_ok) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      sub_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      sub_q     <= sub_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table-driven, hand-sequenced and randomized self-check of uart_rx_core.
// Build with +define+UART_RX_PARITY_EN to exercise the 8E1 variant.
module tb_uart_rx_core;

  localparam int unsigned CLK_FREQ = 614400;
  localparam int unsigned BAUD     = 9600;
  localparam int          DIV      = CLK_FREQ / (BAUD * 16);
  localparam int          BIT      = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam int          EXP_PERR   = 1;
`else
  localparam int          FRAME_BITS = 10;
  localparam int          EXP_PERR   = 0;
`endif
  // Stop-bit middle, plus two synchronizer stages and the start-edge register.
  localparam int          LAT = (2 * FRAME_BITS - 1) * BIT / 2 + 3;

  logic       clk = 1'b0;
  logic       reset, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, parity_err;

  uart_rx_core #(.clk_freq(CLK_FREQ), .baudrate(BAUD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_miss = 0;
  int   cyc = 0, t_start = 0, rise_cyc = -1;
  int   ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
  logic valid_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err)  ferr_cnt++;
    if (overrun)    ovr_cnt++;
    if (parity_err) perr_cnt++;
    if (rx_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = rx_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int brk_bits);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    send_bit(stop_bit);
    if (!stop_bit) begin
      repeat (brk_bits) send_bit(1'b0);
      send_bit(1'b1);
    end
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check(name, rx_valid, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         brk_bits;
    logic       drain;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[9];
  int   f0, o0, p0;
  logic       exp_valid;
  logic [7:0] exp_data;

  initial begin
    vecs[0] = '{8'h55, 1'b1, 0, 1'b1, 1'b1, 8'h55, 0, 0};
    vecs[1] = '{8'hA5, 1'b0, 4, 1'b0, 1'b0, 8'h00, 1, 0};
    vecs[2] = '{8'h3C, 1'b1, 0, 1'b0, 1'b1, 8'h3C, 0, 0};
    vecs[3] = '{8'hC9, 1'b1, 0, 1'b1, 1'b1, 8'h3C, 0, 1};
    vecs[4] = '{8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00, 0, 0};
    vecs[5] = '{8'hFF, 1'b1, 0, 1'b1, 1'b1, 8'h00, 0, 1};
    vecs[6] = '{8'h80, 1'b1, 0, 1'b1, 1'b1, 8'h80, 0, 0};
    vecs[7] = '{8'hE7, 1'b0, 0, 1'b0, 1'b0, 8'h00, 1, 0};
    vecs[8] = '{8'h01, 1'b1, 0, 1'b1, 1'b1, 8'h01, 0, 0};

    reset = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_data", rx_data, 8'h00);
    check("reset_errs", {frame_err, overrun, parity_err}, 3'b000);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].brk_bits);
      check($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) check($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d_frame_err", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_overrun", v), ovr_cnt - o0, vecs[v].exp_ovr);
      if (vecs[v].drain) drain($sformatf("vec%0d_drain", v));
    end

    // Short low glitch, then a byte with the completion latency measured.
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_frame_err", ferr_cnt - f0, 0);
    send_frame(8'hA3, 1'b1, 0);
    check("a3_data", rx_data, 8'hA3);
    check_range("a3_latency", rise_cyc - t_start, LAT - 3, LAT);
    drain("a3_drain");

    // Back-to-back overrun, then acceptance exactly at completion.
    o0 = ovr_cnt;
    send_frame(8'h12, 1'b1, 0);
    send_frame(8'h34, 1'b1, 0);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_data", rx_data, 8'h12);
    check("ovr_pulses", ovr_cnt - o0, 1);
    o0 = ovr_cnt;
    fork
      send_frame(8'h34, 1'b1, 0);
      begin
        repeat (LAT - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    check("same_cycle_valid", rx_valid, 1'b1);
    check("same_cycle_data", rx_data, 8'h34);
    check("same_cycle_overrun", ovr_cnt - o0, 0);
    drain("same_cycle_drain");

    // Reset in the middle of data bit 4 with a byte already held.
    send_frame(8'h6B, 1'b1, 0);
    check("pre_reset_valid", rx_valid, 1'b1);
    f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        repeat (5 * BIT + BIT / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_valid", rx_valid, 1'b0);
        check("midreset_data", rx_data, 8'h00);
        check("midreset_errs", {frame_err, overrun, parity_err}, 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
    join
    check("post_reset_valid", rx_valid, 1'b0);
    check("post_reset_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    send_frame(8'h81, 1'b1, 0);
    check("post_reset_data", rx_data, 8'h81);
    drain("post_reset_drain");

    // Line held low across reset release must not be taken as a start.
    f0 = ferr_cnt;
    reset = 1'b1;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    check("low_reset_valid", rx_valid, 1'b0);
    check("low_reset_frame_err", ferr_cnt - f0, 0);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h5A, 1'b1, 0);
    check("low_reset_next_valid", rx_valid, 1'b1);
    check("low_reset_next_data", rx_data, 8'h5A);
    drain("low_reset_drain");

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 0);
    check("par_ok_valid", rx_valid, 1'b1);
    check("par_ok_data", rx_data, 8'h07);
    check("par_ok_perr", perr_cnt - p0, 0);
    drain("par_ok_drain");
    p0 = perr_cnt; f0 = ferr_cnt;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 0);
    par_flip = 1'b0;
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_valid", rx_valid, 1'b0);
    check("par_bad_frame_err", ferr_cnt - f0, 0);
`endif

    // Random bytes against a holding-register model; consumer drains at random.
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      logic       ok;
      int         want_o;
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(0, BIT)) @(negedge clk);
      f0 = ferr_cnt; o0 = ovr_cnt;
      send_frame(b, ok, int'($urandom_range(0, 3)));
      want_o = (ok && exp_valid) ? 1 : 0;
      if (ok && !exp_valid) begin
        exp_valid = 1'b1;
        exp_data  = b;
      end
      check($sformatf("rnd%0d_valid", k), rx_valid, exp_valid);
      if (exp_valid) check($sformatf("rnd%0d_data", k), rx_data, exp_data);
      check($sformatf("rnd%0d_frame_err", k), ferr_cnt - f0, ok ? 0 : 1);
      check($sformatf("rnd%0d_overrun", k), ovr_cnt - o0, want_o);
      if ($urandom_range(0, 2) == 0) begin
        drain($sformatf("rnd%0d_drain", k));
        exp_valid = 1'b0;
      end
    end

    check("parity_err_total", perr_cnt, EXP_PERR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
